// File: rtl/data_sync_tx_arbiter_pkg.sv
// Shared types and elaboration-time helpers for the DATA_SYNC transmit scheduler.
package data_sync_pkg;

    // Transfer phases: waiting for a request, enable held high, enable held low.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } tx_state_e;

    // Ceiling log2 usable in parameter expressions (clog2_f(1) = 0).
    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Requester index width; never narrower than one bit.
    function automatic int id_width_f(input int num_req);
        int w;
        w = clog2_f(num_req);
        return (w < 1) ? 1 : w;
    endfunction

    // Larger of two integers, for sizing the shared phase counter.
    function automatic int max_f(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/data_sync_tx_arbiter_rr_arbiter.sv
// Round-robin arbiter: pointer register plus combinational first-set search
// starting at the pointer. The pointer moves past the winner on Advance.
module rr_arbiter
    import data_sync_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width_f(NUM_REQ)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] Req,
    input  logic               Advance,
    output logic [NUM_REQ-1:0] Grant_Onehot,
    output logic [ID_W-1:0]    Grant_Idx,
    output logic               Any
);

    logic [ID_W-1:0] ptr_r;
    logic [ID_W-1:0] ptr_nxt_s;
    logic            found_s;
    int              cand_s;
    int              win_s;

    // Search Req starting at the pointer, wrapping modulo NUM_REQ; first hit wins.
    always_comb begin
        found_s = 1'b0;
        cand_s  = 0;
        win_s   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand_s = int'(ptr_r) + off;
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && Req[cand_s[ID_W-1:0]]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Decode the winner into index / one-hot form and the pointer successor.
    always_comb begin
        Grant_Onehot = '0;
        Grant_Idx    = win_s[ID_W-1:0];
        Any          = found_s;
        if (found_s) begin
            Grant_Onehot[win_s[ID_W-1:0]] = 1'b1;
        end else begin
            Grant_Onehot = '0;
        end
        if (win_s >= NUM_REQ - 1) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = ID_W'(win_s + 1);
        end
    end

    // Pointer register: restart at requester 0, step past each granted requester.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_r <= '0;
        end else if (Advance && found_s) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/data_sync_tx_arbiter.sv
// Transmit-domain scheduler sharing one DATA_SYNC crossing between requesters.
// Each transfer captures one winner, raises Bus_Enable for HOLD_CYCLES and then
// keeps it low for GAP_CYCLES, so the destination sees one clean rising edge
// while Tx_Bus is stable.
module data_sync_tx_arbiter
    import data_sync_pkg::*;
#(
    parameter int  NUM_REQ     = 4,
    parameter int  BUS_WIDTH   = 8,
    parameter int  HOLD_CYCLES = 4,
    parameter int  GAP_CYCLES  = 4,
    localparam int ID_W        = id_width_f(NUM_REQ)
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_REQ-1:0]           Req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] Data_In,
    output logic [NUM_REQ-1:0]           Ack,
    output logic [BUS_WIDTH-1:0]         Tx_Bus,
    output logic [ID_W-1:0]              Tx_Id,
    output logic                         Bus_Enable,
    output logic                         Busy
);

    localparam int CNT_W = clog2_f(max_f(HOLD_CYCLES, GAP_CYCLES) + 1);

    tx_state_e            state_r;
    tx_state_e            state_nxt_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_nxt_s;

    logic [NUM_REQ-1:0]   ack_r;
    logic [BUS_WIDTH-1:0] tx_bus_r;
    logic [ID_W-1:0]      tx_id_r;
    logic                 bus_en_r;
    logic                 busy_r;

    logic [NUM_REQ-1:0]   ack_nxt_s;
    logic [BUS_WIDTH-1:0] tx_bus_nxt_s;
    logic [ID_W-1:0]      tx_id_nxt_s;
    logic                 bus_en_nxt_s;
    logic                 busy_nxt_s;

    logic                 advance_s;
    logic [NUM_REQ-1:0]   grant_onehot_s;
    logic [ID_W-1:0]      grant_idx_s;
    logic                 any_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .CLK          (CLK),
        .RST          (RST),
        .Req          (Req),
        .Advance      (advance_s),
        .Grant_Onehot (grant_onehot_s),
        .Grant_Idx    (grant_idx_s),
        .Any          (any_s)
    );

    // Phase sequencing: IDLE waits for a request, HOLD and GAP count down to zero.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_nxt_s = HOLD;
                    cnt_nxt_s   = CNT_W'(HOLD_CYCLES - 1);
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = cnt_r;
                end
            end
            HOLD: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = GAP;
                    cnt_nxt_s   = CNT_W'(GAP_CYCLES - 1);
                end else begin
                    state_nxt_s = HOLD;
                    cnt_nxt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            GAP: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = cnt_r;
                end else begin
                    state_nxt_s = GAP;
                    cnt_nxt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Next output values: capture only on an IDLE grant, enable/busy follow the next phase.
    always_comb begin
        advance_s    = (state_r == IDLE) && any_s;
        ack_nxt_s    = '0;
        tx_bus_nxt_s = tx_bus_r;
        tx_id_nxt_s  = tx_id_r;
        if (advance_s) begin
            ack_nxt_s    = grant_onehot_s;
            tx_bus_nxt_s = Data_In[int'(grant_idx_s)*BUS_WIDTH +: BUS_WIDTH];
            tx_id_nxt_s  = grant_idx_s;
        end else begin
            ack_nxt_s    = '0;
            tx_bus_nxt_s = tx_bus_r;
            tx_id_nxt_s  = tx_id_r;
        end
        bus_en_nxt_s = (state_nxt_s == HOLD);
        busy_nxt_s   = (state_nxt_s != IDLE);
    end

    // State, counter and registered outputs; reset aborts any transfer in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            ack_r    <= '0;
            tx_bus_r <= '0;
            tx_id_r  <= '0;
            bus_en_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            ack_r    <= ack_nxt_s;
            tx_bus_r <= tx_bus_nxt_s;
            tx_id_r  <= tx_id_nxt_s;
            bus_en_r <= bus_en_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    assign Ack        = ack_r;
    assign Tx_Bus     = tx_bus_r;
    assign Tx_Id      = tx_id_r;
    assign Bus_Enable = bus_en_r;
    assign Busy       = busy_r;

endmodule

// File: tb/tb_data_sync_tx_arbiter.sv
// Directed scoreboard bench for data_sync_tx_arbiter (4 requesters, 8-bit bus, 4/4 hold/gap).
module tb_data_sync_tx_arbiter;

    localparam int NREQ   = 4;
    localparam int BW     = 8;
    localparam int HOLD_C = 4;
    localparam int GAP_C  = 4;
    localparam int PERIOD = HOLD_C + GAP_C + 1;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    logic              CLK;
    logic              RST;
    logic [NREQ-1:0]   req;
    logic [7:0]        data [NREQ];
    logic [NREQ*BW-1:0] data_in;
    logic [NREQ-1:0]   Ack;
    logic [BW-1:0]     Tx_Bus;
    logic [1:0]        Tx_Id;
    logic              Bus_Enable;
    logic              Busy;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   c0;
    int   c1;

    assign data_in = {data[3], data[2], data[1], data[0]};

    data_sync_tx_arbiter #(
        .NUM_REQ     (NREQ),
        .BUS_WIDTH   (BW),
        .HOLD_CYCLES (HOLD_C),
        .GAP_CYCLES  (GAP_C)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Req        (req),
        .Data_In    (data_in),
        .Ack        (Ack),
        .Tx_Bus     (Tx_Bus),
        .Tx_Id      (Tx_Id),
        .Bus_Enable (Bus_Enable),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Step until an Ack appears (bounded), then pop and compare the scoreboard head.
    task automatic wait_ack(input string tag, input int budget, output int ack_cyc);
        int   n;
        logic got;
        exp_t e;
        n   = 0;
        got = 1'b0;
        while (!got && n < budget) begin
            step();
            n++;
            if (Ack !== 4'b0000) got = 1'b1;
        end
        ack_cyc = cyc;
        check({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            check({tag, "_sb_nonempty"}, {31'd0, (sb.size() > 0)}, 32'd1);
            e.id   = 0;
            e.data = 8'h00;
            if (sb.size() > 0) e = sb.pop_front();
            check({tag, "_ack"},    {28'd0, Ack},    32'd1 << e.id);
            check({tag, "_id"},     {30'd0, Tx_Id},  e.id);
            check({tag, "_bus"},    {24'd0, Tx_Bus}, {24'd0, e.data});
            check({tag, "_en"},     {31'd0, Bus_Enable}, 32'd1);
            req = req & ~Ack;
        end
    endtask

    // From the first HOLD cycle: check HOLD, GAP and the return to IDLE.
    task automatic check_window(input string tag, input logic [7:0] exp_bus,
                                input logic [3:0] late_mask);
        for (int i = 0; i < HOLD_C; i++) begin
            if (i > 0) step();
            if (i == 1) req = req | late_mask;
            check({tag, "_hold_en"},   {31'd0, Bus_Enable}, 32'd1);
            check({tag, "_hold_busy"}, {31'd0, Busy},       32'd1);
            if (i > 0) check({tag, "_hold_ack"}, {28'd0, Ack}, 32'd0);
        end
        for (int j = 0; j < GAP_C; j++) begin
            step();
            check({tag, "_gap_en"},   {31'd0, Bus_Enable}, 32'd0);
            check({tag, "_gap_busy"}, {31'd0, Busy},       32'd1);
            check({tag, "_gap_ack"},  {28'd0, Ack},        32'd0);
            check({tag, "_gap_bus"},  {24'd0, Tx_Bus},     {24'd0, exp_bus});
        end
        step();
        check({tag, "_idle_busy"}, {31'd0, Busy},       32'd0);
        check({tag, "_idle_en"},   {31'd0, Bus_Enable}, 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (Busy !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_idle"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        RST     = 1'b1;
        req     = 4'b1111;
        data[0] = 8'h3C;
        data[1] = 8'h5A;
        data[2] = 8'h96;
        data[3] = 8'hF0;

        // Reset with all requests high.
        step();
        step();
        check("rst_ack",  {28'd0, Ack},        32'd0);
        check("rst_en",   {31'd0, Bus_Enable}, 32'd0);
        check("rst_busy", {31'd0, Busy},       32'd0);
        check("rst_bus",  {24'd0, Tx_Bus},     32'd0);
        check("rst_id",   {30'd0, Tx_Id},      32'd0);

        RST     = 1'b0;
        req     = 4'b0000;
        data[0] = 8'hA5;
        step();
        check("noreq_ack",  {28'd0, Ack},  32'd0);
        check("noreq_busy", {31'd0, Busy}, 32'd0);

        // Single transfer from requester 0.
        req = 4'b0001;
        sb.push_back('{0, 8'hA5});
        wait_ack("single", 1, c0);
        check_window("single", 8'hA5, 4'b0000);

        // Re-centre the pointer on requester 0, then full contention.
        RST = 1'b1;
        step();
        RST = 1'b0;
        data[0] = 8'h11;
        data[1] = 8'h22;
        data[2] = 8'h33;
        data[3] = 8'h44;
        req = 4'b1111;
        sb.push_back('{0, 8'h11});
        sb.push_back('{1, 8'h22});
        sb.push_back('{2, 8'h33});
        sb.push_back('{3, 8'h44});
        wait_ack("cont", 1, c0);
        for (int k = 1; k < NREQ; k++) begin
            wait_ack("cont", 20, c1);
            check("cont_spacing", c1 - c0, PERIOD);
            c0 = c1;
        end

        // Fairness: grant 2, then 0 and 2 together resolve 0 first.
        req = 4'b0100;
        sb.push_back('{2, 8'h33});
        wait_ack("fair_a", 20, c1);
        check("fair_a_spacing", c1 - c0, PERIOD);
        c0  = c1;
        req = req | 4'b0101;
        sb.push_back('{0, 8'h11});
        sb.push_back('{2, 8'h33});
        wait_ack("fair_b", 20, c1);
        check("fair_b_spacing", c1 - c0, PERIOD);
        c0 = c1;
        wait_ack("fair_c", 20, c1);
        check("fair_c_spacing", c1 - c0, PERIOD);

        // Late request raised during HOLD of requester 0's transfer.
        wait_idle("late");
        data[0] = 8'hA5;
        data[1] = 8'h5A;
        req = 4'b0001;
        sb.push_back('{0, 8'hA5});
        wait_ack("late0", 1, c0);
        sb.push_back('{1, 8'h5A});
        check_window("late0", 8'hA5, 4'b0010);
        wait_ack("late1", 1, c1);

        // Reset during the second HOLD cycle of requester 1 (pointer now 2).
        step();
        check("rmh_pre_en", {31'd0, Bus_Enable}, 32'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("rmh_en",   {31'd0, Bus_Enable}, 32'd0);
        check("rmh_busy", {31'd0, Busy},       32'd0);
        check("rmh_ack",  {28'd0, Ack},        32'd0);
        check("rmh_bus",  {24'd0, Tx_Bus},     32'd0);

        data[2] = 8'hC3;
        req = 4'b0110;
        sb.push_back('{1, 8'h5A});
        sb.push_back('{2, 8'hC3});
        wait_ack("rmh1", 1, c0);
        check_window("rmh1", 8'h5A, 4'b0000);
        wait_ack("rmh2", 1, c1);
        check_window("rmh2", 8'hC3, 4'b0000);

        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
